// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREGS x WIDTH register file with two async read ports,
// one sync write port, r0 hardwired to zero, optional writeback bypass and a
// per-register busy scoreboard used by issue to stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (clears mem and busy)
//   we3, wa3, wd3       writeback enable / address / data
//   ra1, ra2            read addresses
//   rd1, rd2            read data (combinational)
//   iss_valid, iss_rd   issuing instruction valid / destination register
//   busy1, busy2        effective busy of ra1 / ra2 (combinational)
//   stall               issue must hold this cycle (combinational)
//   any_busy            OR of registered busy bits
module regfile_scoreboard #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NREGS  = 8,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             busy1,
  output logic             busy2,
  output logic             stall,
  output logic             any_busy
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] fwd_clr;
  logic [NREGS-1:0] beff;
  logic             wr_en;
  logic             issue;
  logic             waw;

  // Writes to r0 are dropped entirely.
  assign wr_en = we3 && (wa3 != '0);

  // Registers whose busy bit is hidden by a same-cycle forwarded writeback.
  always_comb begin
    fwd_clr = '0;
    if (BYPASS && wr_en) begin
      fwd_clr[wa3] = 1'b1;
    end
  end

  assign beff  = busy_q & ~fwd_clr;
  assign busy1 = beff[ra1];
  assign busy2 = beff[ra2];
  assign waw   = (iss_rd != '0) && beff[iss_rd];
  assign stall = iss_valid && (busy1 || busy2 || waw);
  assign issue = iss_valid && !stall && (iss_rd != '0);
  assign any_busy = |busy_q;

  // Read port 1; reset forces zero so a bypassed wd3 cannot leak out.
  always_comb begin
    rd1 = '0;
    if (rst_n && (ra1 != '0)) begin
      if (BYPASS && we3 && (wa3 == ra1)) begin
        rd1 = wd3;
      end else begin
        rd1 = mem_q[ra1];
      end
    end
  end

  // Read port 2.
  always_comb begin
    rd2 = '0;
    if (rst_n && (ra2 != '0)) begin
      if (BYPASS && we3 && (wa3 == ra2)) begin
        rd2 = wd3;
      end else begin
        rd2 = mem_q[ra2];
      end
    end
  end

  // Scoreboard next state: writeback clears, issue sets afterwards so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wa3] = 1'b0;
    end
    if (issue) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa3] <= wd3;
    end
  end

  // Busy scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one BYPASS=1 and one BYPASS=0
// instance share stimulus; a behavioural model checks both every negedge,
// and literal expectations pin the key scenarios.
module tb_regfile_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       we3;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic       iss_valid;
  logic [2:0] iss_rd;

  logic [7:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic       busy1_b, busy2_b, stall_b, any_busy_b;
  logic       busy1_n, busy2_n, stall_n, any_busy_n;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_scoreboard #(.WIDTH(8), .NREGS(8), .BYPASS(1'b1)) u_bp (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy1(busy1_b), .busy2(busy2_b), .stall(stall_b), .any_busy(any_busy_b)
  );

  regfile_scoreboard #(.WIDTH(8), .NREGS(8), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy1(busy1_n), .busy2(busy2_n), .stall(stall_n), .any_busy(any_busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: one shared memory image, one busy set per bypass flavour.
  logic [7:0] m_mem [8];
  logic [7:0] m_busy [2];

  function automatic logic e_beff(int bp, logic [2:0] r);
    return m_busy[bp][r] && !(bp == 1 && we3 && wa3 == r);
  endfunction

  function automatic logic e_stall(int bp);
    return iss_valid && (e_beff(bp, ra1) || e_beff(bp, ra2) ||
                         (iss_rd != 3'd0 && e_beff(bp, iss_rd)));
  endfunction

  function automatic logic [7:0] e_rd(int bp, logic [2:0] ra);
    if (!rst_n || ra == 3'd0) return 8'h00;
    if (bp == 1 && we3 && wa3 == ra) return wd3;
    return m_mem[ra];
  endfunction

  // Model update on the same edges as the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_busy[0] = 8'h00;
      m_busy[1] = 8'h00;
    end else begin
      logic acc [2];
      for (int bp = 0; bp < 2; bp++)
        acc[bp] = iss_valid && !e_stall(bp) && iss_rd != 3'd0;
      if (we3 && wa3 != 3'd0) begin
        m_mem[wa3] = wd3;
        m_busy[0][wa3] = 1'b0;
        m_busy[1][wa3] = 1'b0;
      end
      for (int bp = 0; bp < 2; bp++)
        if (acc[bp]) m_busy[bp][iss_rd] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_dut(input int bp, input logic [7:0] a1, input logic [7:0] a2,
                         input logic b1, input logic b2, input logic st, input logic ab);
    chk($sformatf("m%0d.rd1", bp), 32'(a1), 32'(e_rd(bp, ra1)));
    chk($sformatf("m%0d.rd2", bp), 32'(a2), 32'(e_rd(bp, ra2)));
    chk($sformatf("m%0d.busy1", bp), 32'(b1), 32'(e_beff(bp, ra1)));
    chk($sformatf("m%0d.busy2", bp), 32'(b2), 32'(e_beff(bp, ra2)));
    chk($sformatf("m%0d.stall", bp), 32'(st), 32'(e_stall(bp)));
    chk($sformatf("m%0d.any_busy", bp), 32'(ab), 32'(m_busy[bp] != 8'h00));
  endtask

  // Model comparison every cycle, away from the active edge.
  always @(negedge clk) begin
    cmp_dut(1, rd1_b, rd2_b, busy1_b, busy2_b, stall_b, any_busy_b);
    cmp_dut(0, rd1_n, rd2_n, busy1_n, busy2_n, stall_n, any_busy_n);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; wa3 = 3'd0; wd3 = 8'h00;
    ra1 = 3'd0; ra2 = 3'd0; iss_valid = 1'b0; iss_rd = 3'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    chk("rst.rd1", 32'(rd1_b), 32'h00);
    chk("rst.any_busy", 32'(any_busy_b), 32'h0);
    rst_n = 1'b1;

    // Write r2, attempt write to r0, read back.
    we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h5C;
    tick();
    we3 = 1'b1; wa3 = 3'd0; wd3 = 8'hFF; ra1 = 3'd2; ra2 = 3'd0;
    #1;
    chk("wr.rd1_r2", 32'(rd1_b), 32'h5C);
    chk("wr.rd2_r0_bypass", 32'(rd2_b), 32'h00);
    tick();
    idle(); ra1 = 3'd2; ra2 = 3'd0;
    #1;
    chk("rd.r2", 32'(rd1_b), 32'h5C);
    chk("rd.r0", 32'(rd2_b), 32'h00);
    chk("rd.r2_nb", 32'(rd1_n), 32'h5C);
    tick();

    // Bypass vs. no bypass.
    idle(); we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h11;
    tick();
    idle(); we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h22; ra1 = 3'd4;
    #1;
    chk("byp.same_cycle", 32'(rd1_b), 32'h22);
    chk("nobyp.same_cycle", 32'(rd1_n), 32'h11);
    tick();
    idle(); ra1 = 3'd4;
    #1;
    chk("byp.next", 32'(rd1_b), 32'h22);
    chk("nobyp.next", 32'(rd1_n), 32'h22);
    tick();

    // RAW stall on r5.
    idle(); iss_valid = 1'b1; iss_rd = 3'd5;
    #1;
    chk("raw.issue_stall", 32'(stall_b), 32'h0);
    tick();
    idle(); iss_valid = 1'b1; iss_rd = 3'd1; ra1 = 3'd5;
    #1;
    chk("raw.any_busy_b", 32'(any_busy_b), 32'h1);
    chk("raw.any_busy_n", 32'(any_busy_n), 32'h1);
    chk("raw.stall_b", 32'(stall_b), 32'h1);
    chk("raw.busy1_b", 32'(busy1_b), 32'h1);
    chk("raw.stall_n", 32'(stall_n), 32'h1);
    tick();
    we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h33;
    #1;
    chk("raw.wb_stall_b", 32'(stall_b), 32'h0);
    chk("raw.wb_busy1_b", 32'(busy1_b), 32'h0);
    chk("raw.wb_stall_n", 32'(stall_n), 32'h1);
    tick();
    we3 = 1'b0;
    #1;
    chk("raw.after_stall_n", 32'(stall_n), 32'h0);
    chk("waw.r1_stall_b", 32'(stall_b), 32'h1);
    tick();
    idle(); we3 = 1'b1; wa3 = 3'd1; wd3 = 8'h01;
    tick();
    idle();
    #1;
    chk("raw.clear_b", 32'(any_busy_b), 32'h0);
    chk("raw.clear_n", 32'(any_busy_n), 32'h0);
    tick();

    // WAW with simultaneous writeback clear and issue set on r6.
    idle(); iss_valid = 1'b1; iss_rd = 3'd6;
    tick();
    we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h44;
    #1;
    chk("waw.stall_b", 32'(stall_b), 32'h0);
    chk("waw.stall_n", 32'(stall_n), 32'h1);
    tick();
    idle(); ra1 = 3'd6;
    #1;
    chk("waw.kept_b", 32'(any_busy_b), 32'h1);
    chk("waw.busy1_b", 32'(busy1_b), 32'h1);
    chk("waw.cleared_n", 32'(any_busy_n), 32'h0);
    tick();
    idle(); we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h45;
    tick();

    // Issue to r0 never marks busy.
    idle(); iss_valid = 1'b1; iss_rd = 3'd0;
    #1;
    chk("r0.stall", 32'(stall_b), 32'h0);
    tick();
    idle();
    #1;
    chk("r0.any_busy", 32'(any_busy_b), 32'h0);
    tick();

    // Mixed traffic, checked by the model each cycle.
    for (int i = 0; i < 200; i++) begin
      we3 = ($urandom_range(0, 2) == 0);
      wa3 = 3'($urandom_range(0, 7));
      wd3 = 8'($urandom_range(0, 255));
      ra1 = 3'($urandom_range(0, 7));
      ra2 = 3'($urandom_range(0, 7));
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd = 3'($urandom_range(0, 7));
      tick();
    end

    // Asynchronous reset mid-operation.
    idle(); we3 = 1'b1; wa3 = 3'd3; wd3 = 8'h77;
    tick();
    idle(); iss_valid = 1'b1; iss_rd = 3'd5;
    tick();
    idle(); we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hAA; ra1 = 3'd3;
    iss_valid = 1'b1; iss_rd = 3'd2;
    #1;
    chk("arst.pre_rd1", 32'(rd1_b), 32'hAA);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.rd1_b", 32'(rd1_b), 32'h00);
    chk("arst.rd1_n", 32'(rd1_n), 32'h00);
    chk("arst.any_busy", 32'(any_busy_b), 32'h0);
    chk("arst.stall", 32'(stall_b), 32'h0);
    tick();
    idle(); rst_n = 1'b1; ra1 = 3'd3;
    #1;
    chk("arst.after_r3", 32'(rd1_b), 32'h00);
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
